debounce_core: RTL and testbench
================================

# debounce_core

Single-input key/switch debouncer: filters a bouncing, asynchronous mechanical input into a clean level plus one-cycle press/release strobes. Sits between a board pin and user logic in FPGA utility designs. A new input level is accepted only after it has been stable for a programmable number of clock cycles. Idle (released) polarity is a parameter, so active-high and active-low keys share one block.

## Interface
- `CLK_FREQ`, default 50: clock frequency in MHz.
- `DELAY_TIME`, default 20: required stability time in µs.
- `DEFAULT_VALUE`, default 0: idle/released level of `ikey`. Pressed level = `~DEFAULT_VALUE`.
- Derived constant `N` = `CLK_FREQ*DELAY_TIME`: stability threshold in cycles. Counter width = clog2(`N`)+1.
- Elaboration-time requirement: `N` ≥ 2.
- `clk`  input  1: sole clock; all logic on the rising edge.
- `rst_n`  input  1: synchronous, active-high reset. The reset is asserted when `rst_n`=1, despite the codebase port name.
- `ikey`  input  1: raw key input, asynchronous and bouncing.
- `okey`  output  1: debounced level, registered.
- `okey_press`  output  1: one-cycle strobe when `okey` leaves `DEFAULT_VALUE`.
- `okey_release`  output  1: one-cycle strobe when `okey` returns to `DEFAULT_VALUE`.

## Operation
- Sample `s`:
  - With `DEBOUNCE_SYNC_EN`: output of a 2-flop synchronizer on `ikey`.
  - Without it: `ikey` as seen at the clock edge.
- Counter `cnt` behaviour at each edge:
  - `s == okey`: `cnt` <= 0.
  - `s != okey` and `cnt < N-1`: `cnt` <= `cnt`+1.
  - `s != okey` and `cnt == N-1`: `okey` <= `s`, `cnt` <= 0.
- Net effect: `okey` changes only after `N` consecutive edges with `s != okey`. Any single sample equal to `okey` restarts the count.
- Strobes, registered and asserted in the same cycle `okey` changes:
  - `okey_press` = 1 when `okey` goes to `~DEFAULT_VALUE`.
  - `okey_release` = 1 when `okey` goes to `DEFAULT_VALUE`.
  - Otherwise both are 0. They are never high together.
- Reset (`rst_n`=1 at an edge):
  - `okey` = `DEFAULT_VALUE`.
  - `cnt` = 0.
  - Both strobes = 0.
  - Synchronizer flops = `DEFAULT_VALUE`.
- Reset has priority over all other logic.
- Reset mid-count discards the partial count. A full `N` stable cycles are needed after release of reset.
- Counter never wraps: it saturates into the accept/clear path at `N-1`.

## Timing
- Latency from an `ikey` change (stable thereafter) to the `okey`/strobe update:
  - Without macro: exactly `N` rising edges, counting the first edge that samples the new value.
  - With macro: `N`+2 edges.
- Glitch rejection: any run of fewer than `N` samples at the new level produces no change.
- Strobe width: exactly 1 cycle.
- Minimum spacing between successive `okey` changes: `N` cycles.
- No handshake; outputs valid every cycle after reset.

## Configuration
- Macro `DEBOUNCE_SYNC_EN`.
- Defined: 2-flop metastability synchronizer on `ikey`; adds 2 cycles latency.
- Undefined: `ikey` sampled directly (caller guarantees synchronous input); latency `N`.

## Test plan
- Reset:
  - Stimulus: `CLK_FREQ`=20, `DELAY_TIME`=2 (`N`=40), clock period 20 ns, `rst_n`=1 for 1 edge.
  - Required: `okey`=`DEFAULT_VALUE`, `okey_press`=`okey_release`=0. Check for both `DEFAULT_VALUE`=0 and 1.
- Bounce rejection:
  - Stimulus: `ikey` toggles with runs of 1–3 cycles for 12 cycles, then returns to idle.
  - Required: `okey` constant, no strobe.
- Clean press:
  - Stimulus: `ikey` held at pressed level for 50 cycles.
  - Required: `okey` flips exactly 40 edges after the change (42 with macro), `okey_press`=1 for exactly that one cycle.
- Threshold boundary:
  - Stimulus: pressed level held 39 cycles, then idle for 1 cycle.
  - Required: no change.
  - Stimulus: pressed level held 40 cycles.
  - Required: change occurs.
- Release:
  - Stimulus: from pressed state, bouncy release, then idle for 50 cycles.
  - Required: `okey` returns to `DEFAULT_VALUE` 40 cycles after the last bounce, `okey_release` one-cycle pulse.
- Reset mid-count:
  - Stimulus: pressed level held, `rst_n`=1 at cycle 30.
  - Required: `okey` stays `DEFAULT_VALUE`, and the change occurs only 40 cycles after reset deasserts.

Source files
------------

// File: rtl/debounce_core_if.sv
// Key debouncer signal bundle: raw key toward the core, clean level and strobes back out.
// master = key source / user logic side, slave = debounce_core side.
interface debounce_core_if;
  logic ikey;
  logic okey;
  logic okey_press;
  logic okey_release;

  modport master (
    output ikey,
    input  okey,
    input  okey_press,
    input  okey_release
  );

  modport slave (
    input  ikey,
    output okey,
    output okey_press,
    output okey_release
  );
endinterface

// File: rtl/debounce_core.sv
// Single-key debouncer: accepts a new level after N = CLK_FREQ*DELAY_TIME stable samples.
// Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop synchronizer on ikey (+2 cycles latency).
module debounce_core #(
  parameter int CLK_FREQ      = 50,
  parameter int DELAY_TIME    = 20,
  parameter bit DEFAULT_VALUE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  debounce_core_if.slave   bus
);
  localparam int N     = CLK_FREQ * DELAY_TIME;
  localparam int CNT_W = $clog2(N) + 1;

  if (N < 2) begin : g_bad_n
    $error("debounce_core: CLK_FREQ*DELAY_TIME must be at least 2");
  end

  // rst_n is active high despite its name.
  logic srst;
  assign srst = rst_n;

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg <= {2{DEFAULT_VALUE}};
    end else begin
      sync_reg <= {sync_reg[0], bus.ikey};
    end
  end

  assign s = sync_reg[1];
`else
  assign s = bus.ikey;
`endif

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             okey_reg, okey_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg     <= '0;
      okey_reg    <= DEFAULT_VALUE;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      okey_reg    <= okey_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  // Any sample matching the current level restarts the count; the count
  // never wraps because reaching N-1 always accepts the new level.
  always_comb begin
    cnt_next     = cnt_reg;
    okey_next    = okey_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    if (s == okey_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_W'(N - 1)) begin
      cnt_next     = '0;
      okey_next    = s;
      press_next   = (s != DEFAULT_VALUE);
      release_next = (s == DEFAULT_VALUE);
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign bus.okey         = okey_reg;
  assign bus.okey_press   = press_reg;
  assign bus.okey_release = release_reg;
endmodule

// File: tb/tb_debounce_core.sv
// Directed bench for debounce_core: two instances (idle-low and idle-high keys) driven with
// the same logical press pattern, N = 20*2 = 40, checked every cycle at the falling edge.
module tb_debounce_core;
`ifdef DEBOUNCE_SYNC_EN
  localparam int LAT = 42;
`else
  localparam int LAT = 40;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  debounce_core_if if0 ();
  debounce_core_if if1 ();

  debounce_core #(.CLK_FREQ(20), .DELAY_TIME(2), .DEFAULT_VALUE(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  debounce_core #(.CLK_FREQ(20), .DELAY_TIME(2), .DEFAULT_VALUE(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic cmp(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // p = logical pressed state; dut1 carries the inverted polarity.
  task automatic check_all(input string tag, input logic p, input logic pr, input logic rl);
    cmp({tag, ":okey0"},    if0.okey,         p);
    cmp({tag, ":okey1"},    if1.okey,         ~p);
    cmp({tag, ":press0"},   if0.okey_press,   pr);
    cmp({tag, ":press1"},   if1.okey_press,   pr);
    cmp({tag, ":release0"}, if0.okey_release, rl);
    cmp({tag, ":release1"}, if1.okey_release, rl);
  endtask

  task automatic set_key(input logic p);
    if0.ikey = p;
    if1.ikey = ~p;
  endtask

  task automatic hold(input int cycles, input logic p, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_all(tag, p, 1'b0, 1'b0);
    end
  endtask

  // Key is already at its new level; the change must land exactly LAT edges later.
  task automatic expect_change(input logic to_p, input string tag);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (i == LAT) check_all(tag, to_p, to_p, ~to_p);
      else          check_all(tag, ~to_p, 1'b0, 1'b0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    set_key(1'b0);

    @(negedge clk);
    check_all("reset", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    hold(3, 1'b0, "idle");

    // Bounce: runs of 1,2,3,1,2,3 cycles alternating pressed/idle.
    begin
      int runs [6] = '{1, 2, 3, 1, 2, 3};
      for (int r = 0; r < 6; r++) begin
        set_key((r % 2) == 0);
        hold(runs[r], 1'b0, "bounce");
      end
    end
    set_key(1'b0);
    hold(LAT + 5, 1'b0, "bounce_settle");

    // Clean press, held 50 cycles total.
    set_key(1'b1);
    expect_change(1'b1, "press");
    hold(50 - LAT, 1'b1, "press_hold");

    // Bouncy release, then idle for 50 cycles.
    set_key(1'b0); hold(2, 1'b1, "rel_bounce");
    set_key(1'b1); hold(1, 1'b1, "rel_bounce");
    set_key(1'b0); hold(1, 1'b1, "rel_bounce");
    set_key(1'b1); hold(3, 1'b1, "rel_bounce");
    set_key(1'b0);
    expect_change(1'b0, "release");
    hold(50 - LAT, 1'b0, "release_hold");

    // Threshold: 39 pressed samples then 1 idle sample must not switch.
    set_key(1'b1); hold(39, 1'b0, "thr_39");
    set_key(1'b0); hold(1, 1'b0, "thr_gap");
    set_key(1'b1);
    expect_change(1'b1, "thr_40");
    hold(3, 1'b1, "thr_after");
    set_key(1'b0);
    expect_change(1'b0, "thr_back");
    hold(3, 1'b0, "thr_idle");

    // Reset at cycle 30 of a held press discards the partial count.
    set_key(1'b1);
    hold(30, 1'b0, "pre_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("mid_rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    expect_change(1'b1, "post_rst");
    hold(3, 1'b1, "post_rst_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
